// File: rtl/decode_pkg.sv
// Shared types for the RV32I decode queue: opcodes, format enum and the
// decoded-instruction record carried through the queue.
package decode_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_R    = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_NONE = 3'd6
    } fmt_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        fmt_t            fmt;
        logic            uses_rs1;
        logic            uses_rs2;
        logic            writes_rd;
        logic            illegal;
    } decoded_t;

endpackage

// File: rtl/instr_decoder.sv
// Combinational RV32I field extractor: raw instruction word -> decoded_t.
// DECODE_RV32E_EN restricts register indices to x0-x15.
module instr_decoder
    import decode_pkg::*;
(
    input  logic [XLEN-1:0] ir,
    input  logic [XLEN-1:0] pc,
    output decoded_t        dec
);

    logic [4:0] f_rs1, f_rs2, f_rd;

    assign f_rs1 = ir[19:15];
    assign f_rs2 = ir[24:20];
    assign f_rd  = ir[11:7];

    always_comb begin
        dec     = '0;
        dec.pc  = pc;
        dec.fmt = FMT_NONE;
        case (ir[6:0])
            OP_LOAD, OP_OPIMM, OP_JALR: begin
                dec.fmt       = FMT_I;
                dec.rs1       = f_rs1;
                dec.rd        = f_rd;
                dec.uses_rs1  = 1'b1;
                dec.writes_rd = (f_rd != 5'd0);
                dec.imm       = {{20{ir[31]}}, ir[31:20]};
            end
            OP_STORE: begin
                dec.fmt      = FMT_S;
                dec.rs1      = f_rs1;
                dec.rs2      = f_rs2;
                dec.uses_rs1 = 1'b1;
                dec.uses_rs2 = 1'b1;
                dec.imm      = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            end
            OP_BRANCH: begin
                dec.fmt      = FMT_B;
                dec.rs1      = f_rs1;
                dec.rs2      = f_rs2;
                dec.uses_rs1 = 1'b1;
                dec.uses_rs2 = 1'b1;
                dec.imm      = {{20{ir[31]}}, ir[7], ir[30:25], ir[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                dec.fmt       = FMT_U;
                dec.rd        = f_rd;
                dec.writes_rd = (f_rd != 5'd0);
                dec.imm       = {ir[31:12], 12'b0};
            end
            OP_JAL: begin
                dec.fmt       = FMT_J;
                dec.rd        = f_rd;
                dec.writes_rd = (f_rd != 5'd0);
                dec.imm       = {{12{ir[31]}}, ir[19:12], ir[20], ir[30:21], 1'b0};
            end
            OP_OP: begin
                dec.fmt       = FMT_R;
                dec.rs1       = f_rs1;
                dec.rs2       = f_rs2;
                dec.rd        = f_rd;
                dec.uses_rs1  = 1'b1;
                dec.uses_rs2  = 1'b1;
                dec.writes_rd = (f_rd != 5'd0);
            end
            default: dec.illegal = 1'b1;
        endcase
`ifdef DECODE_RV32E_EN
        // Upper register bank absent: keep the format, drop every field.
        if (!dec.illegal && ((dec.uses_rs1 && dec.rs1[4]) ||
                             (dec.uses_rs2 && dec.rs2[4]) || dec.rd[4])) begin
            dec.rs1       = '0;
            dec.rs2       = '0;
            dec.rd        = '0;
            dec.imm       = '0;
            dec.uses_rs1  = 1'b0;
            dec.uses_rs2  = 1'b0;
            dec.writes_rd = 1'b0;
            dec.illegal   = 1'b1;
        end
`endif
    end

endmodule

// File: rtl/decode_queue.sv
// Registered RV32I decoder feeding a DEPTH-entry queue of decoded entries,
// with flush. Optional DECODE_RV32E_EN selects RV32E register checking.
module decode_queue
    import decode_pkg::*;
#(
    parameter int NBITS = 32,
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [NBITS-1:0] IR_IN,
    input  logic [NBITS-1:0] PC_IN,
    input  logic             FLUSH,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [NBITS-1:0] PC_OUT,
    output logic [4:0]       RS1,
    output logic [4:0]       RS2,
    output logic [4:0]       RD,
    output logic [NBITS-1:0] IMM,
    output fmt_t             FMT,
    output logic             USES_RS1,
    output logic             USES_RS2,
    output logic             WRITES_RD,
    output logic             ILLEGAL
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    if (NBITS != 32) begin : g_bad_nbits
        $error("decode_queue: only NBITS=32 is supported");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("decode_queue: DEPTH must be a power of two >= 2");
    end

    decoded_t        dec_in;
    decoded_t        head;
    decoded_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            push, pop;

    instr_decoder u_dec (
        .ir  (IR_IN),
        .pc  (PC_IN),
        .dec (dec_in)
    );

    assign IN_READY  = (count < CW'(DEPTH));
    assign OUT_VALID = (count != '0);
    assign push      = IN_VALID && IN_READY;
    assign pop       = OUT_VALID && OUT_READY;

    // Storage carries no reset; validity lives entirely in count.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= dec_in;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (FLUSH) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign head      = OUT_VALID ? mem[rd_ptr] : '0;
    assign PC_OUT    = head.pc;
    assign RS1       = head.rs1;
    assign RS2       = head.rs2;
    assign RD        = head.rd;
    assign IMM       = head.imm;
    assign FMT       = head.fmt;
    assign USES_RS1  = head.uses_rs1;
    assign USES_RS2  = head.uses_rs2;
    assign WRITES_RD = head.writes_rd;
    assign ILLEGAL   = head.illegal;

endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Registered RV32I instruction decoder with an output queue of decoded instructions; sits between fetch and execute.
- Accepts raw instruction words plus PC over a valid/ready handshake.
- Extracts RS1/RS2/RD and the full-format sign-extended immediate (I/S/B/U/J), classifies format, flags illegal encodings.
- Buffers results in a DEPTH-entry FIFO so fetch can run ahead of execute stalls; supports pipeline flush.

Parameters:
NBITS, 32, instruction/PC/immediate width (only 32 supported; elaboration error otherwise)
DEPTH, 4, queue entries; power of two, >=2 (elaboration error otherwise)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous reset, active-high
IN_VALID  in  1  IR_IN/PC_IN valid
IN_READY  out  1  queue can accept this cycle
IR_IN  in  NBITS  raw instruction
PC_IN  in  NBITS  instruction address
FLUSH  in  1  discard all queued entries
OUT_VALID  out  1  head entry valid
OUT_READY  in  1  consumer takes head
PC_OUT  out  NBITS  head PC
RS1, RS2, RD  out  5 each  register indices
IMM  out  NBITS  sign-extended immediate
FMT  out  3  fmt_t: R,I,S,B,U,J,NONE
USES_RS1, USES_RS2, WRITES_RD  out  1 each  operand usage flags
ILLEGAL  out  1  unsupported/malformed encoding

Behaviour:
- Reset (async, RST=1): count=0, rd/wr pointers=0, OUT_VALID=0, IN_READY=1; queue storage not reset. All head outputs read 0 while empty.
- Push when IN_VALID&IN_READY; pop when OUT_VALID&OUT_READY. IN_READY = (count<DEPTH), independent of OUT_READY (no combinational ready path).
- Decode is combinational on IR_IN, written into the queue at push; entry visible on OUT_* the cycle after push (latency 1). No pass-through when empty.
- Simultaneous push+pop: count unchanged, both pointers advance; legal even when full? No — IN_READY=0 when full, so full+pop takes one cycle before refill.
- Pointers wrap modulo DEPTH; count width clog2(DEPTH)+1.
- FLUSH: next cycle count=0, pointers reset, OUT_VALID=0; same-cycle push is discarded; same-cycle pop is ignored.
- Head outputs held stable while OUT_VALID&!OUT_READY.
- Decode by IR[6:0] (IR[1:0]!=2'b11 -> illegal):
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111: FMT=I, RS1, RD, IMM=sext(IR[31:20]).
  - STORE 0100011: FMT=S, RS1, RS2, IMM=sext({IR[31:25],IR[11:7]}).
  - BRANCH 1100011: FMT=B, RS1, RS2, IMM=sext({IR[31],IR[7],IR[30:25],IR[11:8],1'b0}).
  - LUI 0110111, AUIPC 0010111: FMT=U, RD (AUIPC too), IMM={IR[31:12],12'b0}.
  - JAL 1101111: FMT=J, RD, IMM=sext({IR[31],IR[19:12],IR[20],IR[30:21],1'b0}).
  - OP 0110011: FMT=R, RS1, RS2, RD, IMM=0.
  - Unused fields forced to 0 (no latches); usage flags follow field use; WRITES_RD=0 when RD=0.
  - Any other opcode: FMT=NONE, ILLEGAL=1, all fields/flags 0. Illegal entries are still queued in order.

Optional Feature:
- Macro DECODE_RV32E_EN.
- Defined: RV32E mode; any used register index with bit 4 set -> ILLEGAL=1, FMT still reported, fields zeroed.
- Undefined: full 32-register RV32I, bit 4 unchecked.

Decomposition:
- Package decode_pkg: opcode localparams, fmt_t enum, decoded_t packed struct (pc, rs1, rs2, rd, imm, fmt, flags, illegal).
- Sub-module instr_decoder: purely combinational IR -> decoded_t.
- decode_queue: FIFO of decoded_t, handshake, flush.

Test Plan:
- Reset, then push 0xFFF10093 (ADDI x1,x2,-1), PC=0x100 -> next cycle OUT_VALID=1, FMT=I, RS1=2, RD=1, IMM=0xFFFFFFFF, PC_OUT=0x100.
- Push 0xFE000EE3 (BEQ x0,x0,-4) -> FMT=B, RS1=RS2=0, IMM=0xFFFFFFFC. Push 0x001000EF (JAL x1,2048) -> FMT=J, RD=1, IMM=0x00000800. Push 0x123452B7 -> FMT=U, RD=5, IMM=0x12345000.
- OUT_READY=0, push DEPTH=4 entries -> IN_READY=0 after 4th; pop one -> IN_READY=1 next cycle; order preserved across pointer wrap.
- Push 0x00000000 -> ILLEGAL=1, FMT=NONE, all fields 0, queued in order.
- With 3 entries queued, assert FLUSH with IN_VALID=1 -> next cycle OUT_VALID=0, count 0, flushed-cycle instruction absent.
- Assert RST mid-stream with 2 entries -> OUT_VALID=0 immediately (async), IN_READY=1; with DECODE_RV32E_EN, ADD x16,x1,x2 (0x00208833) -> ILLEGAL=1.
